// File: rtl/color_ram_arbiter_if.sv
// Bus bundle between the color RAM arbiter and its requesters:
// CPU write port, pixel lookup port and the single-port RAM.
interface color_ram_arbiter_if;
   logic       CRAM_WR;
   logic [5:0] BA;
   logic [7:0] BD;
   logic       WR_FULL;
   logic       WR_OVF;
   logic       PIX_CE;
   logic [4:0] PIX_ADDR;
   logic [8:0] PIX_COLOR;
   logic       PIX_VALID;
   logic [4:0] RAM_ADDR;
   logic [8:0] RAM_DIN;
   logic       RAM_WE;
   logic [8:0] RAM_DOUT;
   logic       CLEAR_BUSY;

   modport master (
      output CRAM_WR, BA, BD, PIX_CE, PIX_ADDR, RAM_DOUT,
      input  WR_FULL, WR_OVF, PIX_COLOR, PIX_VALID,
      input  RAM_ADDR, RAM_DIN, RAM_WE, CLEAR_BUSY
   );

   modport slave (
      input  CRAM_WR, BA, BD, PIX_CE, PIX_ADDR, RAM_DOUT,
      output WR_FULL, WR_OVF, PIX_COLOR, PIX_VALID,
      output RAM_ADDR, RAM_DIN, RAM_WE, CLEAR_BUSY
   );
endinterface

// File: rtl/color_ram_arbiter.sv
// Color RAM arbiter: shares one 32x9 RAM port between pixel
// lookups (highest priority), a power-up clear and posted CPU
// writes held in a small FIFO.
// Ports: CLK10 clock, RESETn sync active-low reset, bus = slave
// side of color_ram_arbiter_if (CPU, pixel and RAM signals).
module color_ram_arbiter #(
   parameter int         FIFO_AW     = 2,
   parameter logic [8:0] CLEAR_VALUE = 9'h1FF
) (
   input logic                CLK10,
   input logic                RESETn,
   color_ram_arbiter_if.slave bus
);

   localparam int DEPTH = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0] DEPTH_L = (FIFO_AW + 1)'(DEPTH);

   typedef enum logic {
      S_CLEAR,
      S_RUN
   } state_e;

   state_e               state_q, state_d;
   logic [4:0]           clr_q, clr_d;
   logic [13:0]          fifo_q [DEPTH];
   logic [FIFO_AW-1:0]   wp_q, rp_q;
   logic [FIFO_AW:0]     occ_q, occ_d;
   logic                 ovf_q;
   logic                 rd_pend_q;
   logic                 pix_valid_q;
   logic [8:0]           pix_color_q;

   logic                 full, push, drop, pop;
   logic [13:0]          head;
   logic [4:0]           ram_addr;
   logic [8:0]           ram_din;
   logic                 ram_we;

   // Full is judged on start-of-cycle occupancy, so a push
   // into a full FIFO is dropped even if a pop frees a slot.
   assign full = (occ_q == DEPTH_L);
   assign push = bus.CRAM_WR & ~full;
   assign drop = bus.CRAM_WR & full;
   assign head = fifo_q[rp_q];

   always_comb begin
      state_d  = state_q;
      clr_d    = clr_q;
      pop      = 1'b0;
      ram_addr = bus.PIX_ADDR;
      ram_din  = head[8:0];
      ram_we   = 1'b0;
      priority case (1'b1)
         bus.PIX_CE: begin
            ram_addr = bus.PIX_ADDR;
         end
         (state_q == S_CLEAR): begin
            ram_addr = clr_q;
            ram_din  = CLEAR_VALUE;
            ram_we   = 1'b1;
            clr_d    = clr_q + 5'd1;
            if (clr_q == 5'd31) state_d = S_RUN;
         end
         (occ_q != '0): begin
            pop      = 1'b1;
            ram_addr = head[13:9];
            ram_din  = head[8:0];
            ram_we   = 1'b1;
         end
         default: begin
            ram_we = 1'b0;
         end
      endcase
   end

   always_comb begin
      occ_d = occ_q;
      unique case ({push, pop})
         2'b10:   occ_d = occ_q + 1'b1;
         2'b01:   occ_d = occ_q - 1'b1;
         default: occ_d = occ_q;
      endcase
   end

   always_ff @(posedge CLK10) begin
      if (!RESETn) begin
         state_q     <= S_CLEAR;
         clr_q       <= '0;
         wp_q        <= '0;
         rp_q        <= '0;
         occ_q       <= '0;
         ovf_q       <= 1'b0;
         rd_pend_q   <= 1'b0;
         pix_valid_q <= 1'b0;
         pix_color_q <= '0;
      end else begin
         state_q     <= state_d;
         clr_q       <= clr_d;
         occ_q       <= occ_d;
         rd_pend_q   <= bus.PIX_CE;
         pix_valid_q <= rd_pend_q;
         if (push) wp_q <= wp_q + 1'b1;
         if (pop) rp_q <= rp_q + 1'b1;
         if (drop) ovf_q <= 1'b1;
         if (rd_pend_q) pix_color_q <= bus.RAM_DOUT;
      end
   end

   // Storage needs no reset: the pointers define what is valid.
   always_ff @(posedge CLK10) begin
      if (push) begin
         fifo_q[wp_q] <= {bus.BA[4:0], bus.BA[5], bus.BD};
      end
   end

   assign bus.RAM_ADDR   = ram_addr;
   assign bus.RAM_DIN    = ram_din;
   assign bus.RAM_WE     = ram_we & RESETn;
   assign bus.WR_FULL    = full;
   assign bus.WR_OVF     = ovf_q;
   assign bus.PIX_COLOR  = pix_color_q;
   assign bus.PIX_VALID  = pix_valid_q;
   assign bus.CLEAR_BUSY = (state_q == S_CLEAR);

endmodule

// File: tb/tb_color_ram_arbiter.sv
// Self-checking bench for color_ram_arbiter with a RAM model
// and scoreboard queues for RAM writes and pixel results.
module tb_color_ram_arbiter;

   logic clk = 1'b0;
   logic RESETn = 1'b0;
   always #50 clk = ~clk;

   color_ram_arbiter_if bus ();

   color_ram_arbiter #(
      .FIFO_AW(2),
      .CLEAR_VALUE(9'h1FF)
   ) dut (
      .CLK10(clk),
      .RESETn(RESETn),
      .bus(bus)
   );

   logic [8:0]  ram [32];
   logic [13:0] wq [$];
   logic [8:0]  pq [$];
   int          n_chk = 0;
   int          n_pass = 0;

   always @(posedge clk) begin
      if (bus.RAM_WE) ram[bus.RAM_ADDR] <= bus.RAM_DIN;
      bus.RAM_DOUT <= ram[bus.RAM_ADDR];
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", tag, got, exp);
   endtask

   always @(negedge clk) begin
      logic [13:0] e;
      logic [8:0]  p;
      if (!RESETn) begin
         chk("we_in_reset", 32'(bus.RAM_WE), 32'd0);
      end else begin
         if (bus.RAM_WE) begin
            chk("wr_slot", 32'(bus.PIX_CE), 32'd0);
            if (wq.size() == 0) begin
               chk("wr_unexp", 32'(bus.RAM_WE), 32'd0);
            end else begin
               e = wq.pop_front();
               chk("wr_addr", 32'(bus.RAM_ADDR), 32'(e[13:9]));
               chk("wr_data", 32'(bus.RAM_DIN), 32'(e[8:0]));
            end
         end
         if (bus.PIX_CE) begin
            chk("pix_slot", 32'({bus.RAM_WE, bus.RAM_ADDR}),
                32'({1'b0, bus.PIX_ADDR}));
         end
      end
      if (bus.PIX_VALID) begin
         if (pq.size() == 0) begin
            chk("pix_unexp", 32'(bus.PIX_VALID), 32'd0);
         end else begin
            p = pq.pop_front();
            chk("pix_color", 32'(bus.PIX_COLOR), 32'(p));
         end
      end
   end

   task automatic step(input bit pce, input logic [4:0] pa,
                       input logic [8:0] pexp, input bit wr,
                       input logic [5:0] ba, input logic [7:0] bd,
                       input bit drop);
      @(posedge clk);
      #1;
      bus.PIX_CE   = pce;
      bus.PIX_ADDR = pa;
      bus.CRAM_WR  = wr;
      bus.BA       = ba;
      bus.BD       = bd;
      if (pce) pq.push_back(pexp);
      if (wr && !drop) wq.push_back({ba[4:0], ba[5], bd});
   endtask

   task automatic idle();
      step(1'b0, 5'd0, 9'd0, 1'b0, 6'd0, 8'd0, 1'b0);
   endtask

   task automatic do_reset(input int n);
      @(posedge clk);
      #1;
      RESETn       = 1'b0;
      bus.PIX_CE   = 1'b0;
      bus.PIX_ADDR = '0;
      bus.CRAM_WR  = 1'b0;
      bus.BA       = '0;
      bus.BD       = '0;
      wq.delete();
      pq.delete();
      repeat (n - 1) @(posedge clk);
      @(posedge clk);
      #1;
      RESETn = 1'b1;
      for (int i = 0; i < 32; i++) wq.push_back({5'(i), 9'h1FF});
   endtask

   task automatic chk_reset_vals();
      @(negedge clk);
      chk("rst_color", 32'(bus.PIX_COLOR), 32'd0);
      chk("rst_valid", 32'(bus.PIX_VALID), 32'd0);
      chk("rst_full", 32'(bus.WR_FULL), 32'd0);
      chk("rst_ovf", 32'(bus.WR_OVF), 32'd0);
      chk("rst_busy", 32'(bus.CLEAR_BUSY), 32'd1);
   endtask

   task automatic drain_wait(input int max);
      for (int i = 0; i < max && (wq.size() != 0 || pq.size() != 0); i++)
         idle();
      chk("drain_wq", 32'(wq.size()), 32'd0);
      chk("drain_pq", 32'(pq.size()), 32'd0);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bus.PIX_CE   = 1'b0;
      bus.PIX_ADDR = '0;
      bus.CRAM_WR  = 1'b0;
      bus.BA       = '0;
      bus.BD       = '0;

      // Clear sequence and first lookup
      do_reset(2);
      chk_reset_vals();
      chk("clr_we0", 32'(bus.RAM_WE), 32'd1);
      for (int i = 1; i < 32; i++) begin
         idle();
         @(negedge clk);
         chk("clr_busy", 32'(bus.CLEAR_BUSY), 32'd1);
         chk("clr_we", 32'(bus.RAM_WE), 32'd1);
      end
      idle();
      @(negedge clk);
      chk("clr_done", 32'(bus.CLEAR_BUSY), 32'd0);
      chk("clr_we_off", 32'(bus.RAM_WE), 32'd0);
      step(1'b1, 5'd17, 9'h1FF, 1'b0, 6'd0, 8'd0, 1'b0);
      idle();
      @(negedge clk);
      chk("lat_n1", 32'(bus.PIX_VALID), 32'd0);
      idle();
      @(negedge clk);
      chk("lat_n2", 32'(bus.PIX_VALID), 32'd1);
      drain_wait(20);

      // CPU write while PIX_CE toggles
      for (int i = 0; i < 10; i++)
         step(i % 2 == 0, 5'd10, 9'h1FF, i == 0, 6'h25, 8'hA5, 1'b0);
      idle();
      step(1'b1, 5'd5, 9'h1A5, 1'b0, 6'd0, 8'd0, 1'b0);
      drain_wait(20);

      // Starvation, full and overflow
      do_reset(2);
      chk_reset_vals();
      repeat (32) idle();
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 5'd20, 9'h1FF, 1'b1, 6'(i), 8'(8'h30 + i), i == 4);
         @(negedge clk);
         chk("fill_we", 32'(bus.RAM_WE), 32'd0);
         if (i == 3) chk("full_occ3", 32'(bus.WR_FULL), 32'd0);
         if (i == 4) chk("full_occ4", 32'(bus.WR_FULL), 32'd1);
      end
      idle();
      @(negedge clk);
      chk("ovf_set", 32'(bus.WR_OVF), 32'd1);
      chk("drain_we0", 32'(bus.RAM_WE), 32'd1);
      for (int i = 1; i < 4; i++) begin
         idle();
         @(negedge clk);
         chk("drain_we", 32'(bus.RAM_WE), 32'd1);
      end
      idle();
      @(negedge clk);
      chk("drain_end", 32'(bus.RAM_WE), 32'd0);
      drain_wait(20);

      // CPU writes during clear override the clear value
      do_reset(2);
      chk_reset_vals();
      step(1'b0, 5'd0, 9'd0, 1'b1, 6'h01, 8'h11, 1'b0);
      step(1'b0, 5'd0, 9'd0, 1'b1, 6'h02, 8'hF0, 1'b0);
      step(1'b0, 5'd0, 9'd0, 1'b1, 6'h23, 8'h33, 1'b0);
      @(negedge clk);
      chk("cw_busy", 32'(bus.CLEAR_BUSY), 32'd1);
      drain_wait(60);
      step(1'b1, 5'd2, 9'h0F0, 1'b0, 6'd0, 8'd0, 1'b0);
      step(1'b1, 5'd3, 9'h133, 1'b0, 6'd0, 8'd0, 1'b0);
      drain_wait(20);

      // Simultaneous push and pop at occupancy 2 and 4
      step(1'b1, 5'd9, 9'h1FF, 1'b1, 6'h0A, 8'hA1, 1'b0);
      step(1'b1, 5'd9, 9'h1FF, 1'b1, 6'h0B, 8'hB2, 1'b0);
      step(1'b0, 5'd0, 9'd0, 1'b1, 6'h0C, 8'hC3, 1'b0);
      @(negedge clk);
      chk("pp2_full", 32'(bus.WR_FULL), 32'd0);
      chk("pp2_we", 32'(bus.RAM_WE), 32'd1);
      step(1'b1, 5'd9, 9'h1FF, 1'b0, 6'd0, 8'd0, 1'b0);
      @(negedge clk);
      chk("pp2_ovf", 32'(bus.WR_OVF), 32'd0);
      step(1'b1, 5'd9, 9'h1FF, 1'b1, 6'h0D, 8'hD4, 1'b0);
      @(negedge clk);
      chk("pp_occ2", 32'(bus.WR_FULL), 32'd0);
      step(1'b1, 5'd9, 9'h1FF, 1'b1, 6'h0E, 8'hE5, 1'b0);
      @(negedge clk);
      chk("pp_occ3", 32'(bus.WR_FULL), 32'd0);
      step(1'b0, 5'd0, 9'd0, 1'b1, 6'h0F, 8'hF6, 1'b1);
      @(negedge clk);
      chk("pp4_full", 32'(bus.WR_FULL), 32'd1);
      chk("pp4_we", 32'(bus.RAM_WE), 32'd1);
      idle();
      @(negedge clk);
      chk("pp4_ovf", 32'(bus.WR_OVF), 32'd1);
      drain_wait(20);

      // Reset mid-drain with a lookup pending
      for (int i = 0; i < 3; i++)
         step(1'b1, 5'd9, 9'h1FF, 1'b1, 6'(5'd24 + 5'(i)), 8'h5A, 1'b0);
      idle();
      step(1'b1, 5'd9, 9'h1FF, 1'b0, 6'd0, 8'd0, 1'b0);
      do_reset(1);
      chk_reset_vals();
      drain_wait(60);
      repeat (8) idle();
      chk("end_wq", 32'(wq.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/color_ram_arbiter.md
# color_ram_arbiter

Sequencer and arbiter for the 32-entry × 9-bit color RAM. It shares the single RAM port between three requesters:
- pixel-rate palette lookups from the video pipeline;
- CPU palette writes, posted through a small FIFO;
- a power-up clear sequencer.

Pixel lookups always win their slot. CPU writes and clear writes are drained only in cycles without a pixel lookup, so video timing is never disturbed by CPU traffic.

## Interface
Parameters:
- `FIFO_AW`, default 2: CPU write FIFO depth is 2^FIFO_AW entries (4).
- `CLEAR_VALUE`, default 9'h1FF: word written to every entry after reset (inverted palette output, so this gives black).

Ports:
- `CLK10` in 1: single clock, 10 MHz domain.
- `RESETn` in 1: reset is synchronous and active-low.
- `CRAM_WR` in 1: one-cycle CPU palette write strobe, already synchronous to `CLK10`.
- `BA` in 6: CPU address. Write index = `BA[4:0]`; `BA[5]` is data bit 8.
- `BD` in 8: CPU data, bits 7:0.
- `WR_FULL` out 1: FIFO full.
- `WR_OVF` out 1: sticky flag, set when a write is dropped.
- `PIX_CE` in 1: pixel lookup request this cycle.
- `PIX_ADDR` in 5: lookup index.
- `PIX_COLOR` out 9: looked-up word.
- `PIX_VALID` out 1: one-cycle pulse, `PIX_COLOR` updated.
- `RAM_ADDR` out 5: RAM address.
- `RAM_DIN` out 9: RAM write data.
- `RAM_WE` out 1: RAM write enable.
- `RAM_DOUT` in 9: synchronous RAM read data, valid one cycle after the address.
- `CLEAR_BUSY` out 1: clear sequence in progress.

## Operation
- State machine: `CLEAR` → `RUN`. Reset always enters `CLEAR` with the clear counter at 0.
- Slot arbitration each cycle, in priority order:
  1. `PIX_CE`=1: `RAM_ADDR`=`PIX_ADDR`, `RAM_WE`=0.
  2. Else, in `CLEAR`: `RAM_ADDR`=counter, `RAM_DIN`=`CLEAR_VALUE`, `RAM_WE`=1, counter increments.
  3. Else, in `RUN` with the FIFO non-empty: pop the head; `RAM_ADDR`/`RAM_DIN` come from the entry; `RAM_WE`=1.
  4. Else: `RAM_WE`=0, `RAM_ADDR`=`PIX_ADDR`.
- `RAM_ADDR`, `RAM_DIN` and `RAM_WE` are combinational from registered state and the current `PIX_CE`/`PIX_ADDR`.
- Clear sequence:
  - Exits to `RUN` after the write to index 31.
  - The counter is 5 bits; it wraps to 0 and is not reused.
  - `CLEAR_BUSY`=1 throughout `CLEAR`.
- CPU writes:
  - On `CRAM_WR`=1, the entry {`BA[4:0]`, {`BA[5]`,`BD`}} is pushed, in any state.
  - Writes accepted during `CLEAR` drain only after clear completes, so CPU data overrides the clear value.
  - Write order is preserved.
- Full handling:
  - `WR_FULL` reflects the occupancy registered at the start of the cycle.
  - A push while `WR_FULL`=1 is dropped and sets `WR_OVF`, even if a pop occurs in the same cycle.
  - `WR_OVF` clears only on reset.
- Simultaneous push and pop when not full: both happen; occupancy is unchanged.
- Push into an empty FIFO: the entry is not written in the same cycle. It is eligible from the next cycle.
- Lookup pipeline: `PIX_CE` is delayed 1 cycle into a `rd_pend` flag. When `rd_pend`=1, `PIX_COLOR` ← `RAM_DOUT` and `PIX_VALID` pulses.
- Read during write (same index, different cycles): a read issued the cycle after a write returns the new value.

## Timing
- Reset values: `PIX_COLOR`=0, `PIX_VALID`=0, `WR_FULL`=0, `WR_OVF`=0, `CLEAR_BUSY`=1, FIFO empty, counter=0.
- `RAM_WE` is forced to 0 while `RESETn`=0.
- Reset mid-operation flushes the FIFO and restarts the clear at index 0. Any pending lookup is discarded, so no `PIX_VALID` follows.
- Lookup latency:
  - `PIX_CE` in cycle N → RAM samples the address at the end of N.
  - `RAM_DOUT` is valid in N+1.
  - `PIX_COLOR`/`PIX_VALID` are visible in N+2.
  - Back-to-back `PIX_CE` is fully pipelined: one result per cycle.
- Write latency: `CRAM_WR` in cycle N → earliest `RAM_WE` in N+1, provided `PIX_CE`=0 and the state is `RUN`.
- Clear duration: 32 non-`PIX_CE` cycles. With `PIX_CE` at 50% duty, clear takes 64 cycles.
- Starvation: with `PIX_CE` held at 1 continuously, no write is performed. FIFO fill and overflow follow the rules above.

## Test plan
- Reset, `PIX_CE`=0 → `RAM_WE`=1 for 32 consecutive cycles writing 9'h1FF to indices 0..31. `CLEAR_BUSY` falls after index 31. Reading index 17 then returns 9'h1FF in N+2.
- After clear, `PIX_CE` toggling every cycle; CPU writes `BA`=6'h25, `BD`=8'hA5 → one write to index 5 with data 9'h1A5, only in a `PIX_CE`=0 cycle. A later lookup of index 5 → `PIX_COLOR`=9'h1A5.
- `PIX_CE` held high; 5 CPU writes to indices 0..4 → 4 accepted, `WR_FULL`=1, 5th dropped, `WR_OVF`=1. After `PIX_CE` drops, the 4 writes land in order in 4 cycles.
- 3 CPU writes during `CLEAR` (index 2 ← 9'h0F0) → after clear, index 2 reads 9'h0F0, not 9'h1FF.
- Push and pop in the same cycle with occupancy 2 → occupancy stays 2, `WR_OVF`=0. Repeat at occupancy 4 → write dropped, `WR_OVF`=1.
- `RESETn` low for 1 cycle mid-drain with a lookup pending → FIFO empty, no `PIX_VALID`, clear restarts at index 0.
